// File: rtl/reg_file_pkg.sv
// ============================================================================
// Module      : reg_file_pkg
// Description : Shared defaults and clear-engine state encoding for reg_file_mp.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package reg_file_pkg;

    localparam int XLEN_DEF = 32;
    localparam int NREG_DEF = 32;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_CLEAR = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

endpackage

`default_nettype wire

// File: rtl/reg_file_clr_fsm.sv
// ============================================================================
// Module      : reg_file_clr_fsm
// Description : Sequential clear engine; walks every entry once, then pulses done.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module reg_file_clr_fsm
    import reg_file_pkg::*;
#(
    parameter int NREG = NREG_DEF,
    localparam int AW  = $clog2(NREG)
) (
    input  logic          i_clk,
    input  logic          i_reset_n,
    input  logic          i_clr_req,
    output logic          o_busy,
    output logic          o_clr_done,
    output logic          o_clr_we,
    output logic [AW-1:0] o_clr_addr
);

    typedef enum logic [1:0] {
        S_IDLE  = ST_IDLE,
        S_CLEAR = ST_CLEAR,
        S_DONE  = ST_DONE
    } state_t;

    localparam logic [AW-1:0] c_last_idx = AW'(NREG - 1);

    state_t        r_state;
    state_t        w_state_next;
    logic [AW-1:0] r_idx;
    logic [AW-1:0] w_idx_next;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_next;
            r_idx   <= w_idx_next;
        end
    end

    // DONE never looks at the request, so a held request costs one idle cycle.
    always_comb begin
        w_state_next = r_state;
        w_idx_next   = r_idx;
        case (r_state)
            S_IDLE: begin
                if (i_clr_req) begin
                    w_state_next = S_CLEAR;
                    w_idx_next   = '0;
                end
            end
            S_CLEAR: begin
                if (r_idx == c_last_idx) begin
                    w_state_next = S_DONE;
                    w_idx_next   = '0;
                end else begin
                    w_idx_next = r_idx + 1'b1;
                end
            end
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    assign o_busy     = (r_state == S_CLEAR);
    assign o_clr_done = (r_state == S_DONE);
    assign o_clr_we   = (r_state == S_CLEAR);
    assign o_clr_addr = r_idx;

endmodule

`default_nettype wire

// File: rtl/reg_file_mp.sv
// ============================================================================
// Module      : reg_file_mp
// Description : 2-read / 2-write register file with sequential clear engine.
//               Optional macro REG_FILE_MP_BYPASS_EN enables write-through reads.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module reg_file_mp
    import reg_file_pkg::*;
#(
    parameter int XLEN     = XLEN_DEF,
    parameter int NREG     = NREG_DEF,
    parameter int ZERO_REG = 1,
    localparam int AW      = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [AW-1:0]   ra,
    input  logic [AW-1:0]   rb,
    output logic [XLEN-1:0] douta,
    output logic [XLEN-1:0] doutb,
    input  logic            we0,
    input  logic [AW-1:0]   rw0,
    input  logic [XLEN-1:0] din0,
    input  logic            we1,
    input  logic [AW-1:0]   rw1,
    input  logic [XLEN-1:0] din1,
    input  logic            clr_req,
    output logic            busy,
    output logic            clr_done
);

    logic [XLEN-1:0] r_mem [NREG];
    logic            w_busy;
    logic            w_clr_we;
    logic [AW-1:0]   w_clr_addr;

    reg_file_clr_fsm #(
        .NREG (NREG)
    ) u_clr_fsm (
        .i_clk      (clk),
        .i_reset_n  (reset_n),
        .i_clr_req  (clr_req),
        .o_busy     (w_busy),
        .o_clr_done (clr_done),
        .o_clr_we   (w_clr_we),
        .o_clr_addr (w_clr_addr)
    );

    assign busy = w_busy;

    // Clear beats external writes; port 1 beats port 0 on the same address.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NREG; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NREG; i++) begin
                if (ZERO_REG != 0 && i == 0) begin
                    r_mem[i] <= '0;
                end else if (w_clr_we && w_clr_addr == AW'(i)) begin
                    r_mem[i] <= '0;
                end else if (!w_busy && we1 && rw1 == AW'(i)) begin
                    r_mem[i] <= din1;
                end else if (!w_busy && we0 && rw0 == AW'(i)) begin
                    r_mem[i] <= din0;
                end
            end
        end
    end

`ifdef REG_FILE_MP_BYPASS_EN
    logic w_byp_ok_a;
    logic w_byp_ok_b;

    assign w_byp_ok_a = !w_busy && !(ZERO_REG != 0 && ra == '0);
    assign w_byp_ok_b = !w_busy && !(ZERO_REG != 0 && rb == '0);

    always_comb begin
        douta = r_mem[ra];
        if (w_byp_ok_a && we1 && rw1 == ra) begin
            douta = din1;
        end else if (w_byp_ok_a && we0 && rw0 == ra) begin
            douta = din0;
        end
    end

    always_comb begin
        doutb = r_mem[rb];
        if (w_byp_ok_b && we1 && rw1 == rb) begin
            doutb = din1;
        end else if (w_byp_ok_b && we0 && rw0 == rb) begin
            doutb = din0;
        end
    end
`else
    assign douta = r_mem[ra];
    assign doutb = r_mem[rb];
`endif

endmodule

`default_nettype wire
